// File: rtl/rect_anim_pkg.sv
// Shared types and constants for the rectangle animator.
package rect_anim_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    WAIT  = 3'd2,
    ERASE = 3'd3,
    MOVE  = 3'd4
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_pixel_scanner.sv
// Walks px (fastest), then py, then rectangle index; one step per enabled cycle.
module rect_pixel_scanner
  import rect_anim_pkg::*;
#(
  parameter int NUM_RECTS = 2,
  parameter int RECT_W    = 40,
  parameter int RECT_H    = 5,
  localparam int PXW = cnt_w(RECT_W),
  localparam int PYW = cnt_w(RECT_H),
  localparam int IW  = cnt_w(NUM_RECTS)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           enable,
  output logic [PXW-1:0] px,
  output logic [PYW-1:0] py,
  output logic [IW-1:0]  idx,
  output logic           last
);

  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           px_max, py_max, idx_max;

  assign px_max  = (px_q  == PXW'(RECT_W - 1));
  assign py_max  = (py_q  == PYW'(RECT_H - 1));
  assign idx_max = (idx_q == IW'(NUM_RECTS - 1));
  assign last    = px_max && py_max && idx_max;

  assign px  = px_q;
  assign py  = py_q;
  assign idx = idx_q;

  // Next position: clear wins over enable; each level rolls over into the next.
  always_comb begin
    px_d  = px_q;
    py_d  = py_q;
    idx_d = idx_q;
    if (clear) begin
      px_d  = '0;
      py_d  = '0;
      idx_d = '0;
    end else if (enable) begin
      if (px_max) begin
        px_d = '0;
        if (py_max) begin
          py_d  = '0;
          idx_d = idx_max ? '0 : idx_q + IW'(1);
        end else begin
          py_d = py_q + PYW'(1);
        end
      end else begin
        px_d = px_q + PXW'(1);
      end
    end
  end

  // Scanner position registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px_q  <= '0;
      py_q  <= '0;
      idx_q <= '0;
    end else begin
      px_q  <= px_d;
      py_q  <= py_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/rect_animator.sv
// Draws, holds, erases and moves NUM_RECTS rectangles on a 160x120 VGA adapter.
// Pixel outputs are combinational decodes of the registered state/scanner.
module rect_animator
  import rect_anim_pkg::*;
#(
  parameter int               NUM_RECTS       = 2,
  parameter int               RECT_W          = 40,
  parameter int               RECT_H          = 5,
  parameter int               FRAME_TICKS     = 833334,
  parameter int               FRAMES_PER_STEP = 4,
  parameter int               STEP            = 1,
  parameter int               Y_WRAP          = 116,
  parameter logic [COL_W-1:0] BG_COLOUR       = 3'b000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       go,
  input  logic                       pause,
  input  logic [X_W*NUM_RECTS-1:0]   init_x,
  input  logic [Y_W*NUM_RECTS-1:0]   init_y,
  input  logic [COL_W*NUM_RECTS-1:0] init_colour,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [COL_W-1:0]           colour,
  output logic                       plot,
  output logic                       busy,
  output logic                       step_done
);

  localparam int PXW = cnt_w(RECT_W);
  localparam int PYW = cnt_w(RECT_H);
  localparam int IW  = cnt_w(NUM_RECTS);
  localparam int TW  = cnt_w(FRAME_TICKS);
  localparam int FW  = cnt_w(FRAMES_PER_STEP + 1);

  state_e           state_q, state_d;
  logic             go_q, go_d, go_edge;
  logic [TW-1:0]    tick_q, tick_d;
  logic [FW-1:0]    frame_q, frame_d, frame_inc;
  logic [X_W-1:0]   rx_q [NUM_RECTS];
  logic [X_W-1:0]   rx_d [NUM_RECTS];
  logic [Y_W-1:0]   ry_q [NUM_RECTS];
  logic [Y_W-1:0]   ry_d [NUM_RECTS];
  logic [COL_W-1:0] rc_q [NUM_RECTS];
  logic [COL_W-1:0] rc_d [NUM_RECTS];

  logic [PXW-1:0]   px;
  logic [PYW-1:0]   py;
  logic [IW-1:0]    idx;
  logic             scan_last, scan_clear, scan_en;
  logic [7:0]       sum_x, sum_y;
  logic             in_scan;

  assign go_edge   = go & ~go_q;
  assign frame_inc = frame_q + FW'(1);
  assign in_scan   = (state_q == DRAW) || (state_q == ERASE);
  // The scanner restarts on every state change so each pass begins at pixel 0.
  assign scan_clear = (state_d != state_q);
  assign scan_en    = in_scan;

  rect_pixel_scanner #(
    .NUM_RECTS (NUM_RECTS),
    .RECT_W    (RECT_W),
    .RECT_H    (RECT_H)
  ) u_scanner (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (scan_clear),
    .enable  (scan_en),
    .px      (px),
    .py      (py),
    .idx     (idx),
    .last    (scan_last)
  );

  // Pixel address: 8-bit sums so off-screen coordinates can be detected and clipped.
  always_comb begin
    sum_x = rx_q[idx] + 8'(px);
    sum_y = {1'b0, ry_q[idx]} + 8'(py);
  end

  assign x         = sum_x;
  assign y         = sum_y[Y_W-1:0];
  assign plot      = in_scan && (sum_x < 8'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
  assign busy      = (state_q != IDLE);
  assign step_done = (state_q == MOVE);

  // Pixel colour: rectangle colour when drawing, background when erasing.
  always_comb begin
    colour = '0;
    if (state_q == DRAW)       colour = rc_q[idx];
    else if (state_q == ERASE) colour = BG_COLOUR;
  end

  // Next-state, frame timing and rectangle register updates.
  always_comb begin
    state_d = state_q;
    go_d    = go;
    tick_d  = tick_q;
    frame_d = frame_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        if (go_edge) begin
          for (int i = 0; i < NUM_RECTS; i++) begin
            rx_d[i] = init_x[X_W*i +: X_W];
            ry_d[i] = init_y[Y_W*i +: Y_W];
            rc_d[i] = init_colour[COL_W*i +: COL_W];
          end
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (scan_last) begin
          tick_d  = '0;
          frame_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!pause) begin
          if (tick_q == TW'(FRAME_TICKS - 1)) begin
            tick_d  = '0;
            frame_d = frame_inc;
            if (frame_inc == FW'(FRAMES_PER_STEP)) state_d = ERASE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ERASE: begin
        if (scan_last) state_d = MOVE;
      end
      MOVE: begin
        for (int i = 0; i < NUM_RECTS; i++) begin
          ry_d[i] = (ry_q[i] < Y_W'(STEP)) ? Y_W'(Y_WRAP) : ry_q[i] - Y_W'(STEP);
        end
        state_d = DRAW;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and per-rectangle registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      tick_q  <= '0;
      frame_q <= '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        rx_q[i] <= '0;
        ry_q[i] <= '0;
        rc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rc_q    <= rc_d;
    end
  end

endmodule
